// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the add/subtract unit
package adder_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } add_flags_t;

endpackage

// File: rtl/adder_unit_cla4.sv
// rtl/adder_unit_cla4.sv - 4-bit carry-lookahead block with group generate/propagate
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Fully expanded lookahead so no carry ripples inside the block.
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign s = pi ^ c;

  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;

endmodule

// File: rtl/adder_unit.sv
// rtl/adder_unit.sv - registered two's-complement add/subtract unit with status flags
module adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_p;
  logic [NB:0]      blk_c;

  logic [WIDTH-1:0] o_q, o_d;
  add_flags_t       flags_q, flags_d;

  assign b_eff = b ^ {WIDTH{sub}};

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla4 u_cla4 (
      .a   (a[4*k +: 4]),
      .b   (b_eff[4*k +: 4]),
      .cin (blk_c[k]),
      .s   (sum[4*k +: 4]),
      .g   (blk_g[k]),
      .p   (blk_p[k])
    );
  end

  // Second-level carry chain across blocks; cin of the whole adder is sub.
  always_comb begin
    blk_c    = '0;
    blk_c[0] = sub;
    for (int k = 0; k < NB; k++) begin
      blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
    end
  end

  always_comb begin
    o_d              = sum;
    flags_d.carry    = blk_c[NB];
    flags_d.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    flags_d.zero     = (sum == '0);
    flags_d.negative = sum[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q     <= '0;
      flags_q <= '{carry: 1'b0, overflow: 1'b0, zero: 1'b1, negative: 1'b0};
    end else begin
      o_q     <= o_d;
      flags_q <= flags_d;
    end
  end

  assign o        = o_q;
  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign negative = flags_q.negative;

endmodule

// File: tb/tb_adder_unit.sv
// tb/tb_adder_unit.sv - scoreboard bench for adder_unit against an arithmetic reference model
module tb_adder_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic [31:0] o;
  logic        carry, overflow, zero, negative;

  typedef struct packed {
    logic [31:0] o;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  adder_unit dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .o        (o),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on wide values, no bit-level tricks.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t        e;
    longint      ux, uy, sx, sy, full, strue;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      full  = ux - uy;
      strue = sx - sy;
      e.c   = (ux >= uy);
    end else begin
      full  = ux + uy;
      strue = sx + sy;
      e.c   = (full >= 64'sd4294967296);
    end
    e.o = full[31:0];
    e.v = (strue > 64'sd2147483647) || (strue < -64'sd2147483648);
    e.z = (e.o == 32'd0);
    e.n = e.o[31];
    return e;
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(posedge clk);
    #2;
    a   = x;
    b   = y;
    sub = s;
    exp_q.push_back(model(x, y, s));
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("o",        o,               e.o);
      check("carry",    {31'b0, carry},    {31'b0, e.c});
      check("overflow", {31'b0, overflow}, {31'b0, e.v});
      check("zero",     {31'b0, zero},     {31'b0, e.z});
      check("negative", {31'b0, negative}, {31'b0, e.n});
    end
  end

  initial begin
    int wait_cnt;
    a = 32'd5; b = 32'd3; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("pre_reset_o", o, 32'd8);

    // Assert reset away from any clock edge; outputs must clear immediately.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_o",        o,               32'd0);
    check("rst_zero",     {31'b0, zero},     32'd1);
    check("rst_carry",    {31'b0, carry},    32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_negative", {31'b0, negative}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold_o", o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    mon_en = 1'b1;
    drive(32'd5, 32'd3, 1'b0);
    drive(32'd5, 32'd3, 1'b1);
    drive(32'd3, 32'd5, 1'b1);
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);
    drive(32'd0, 32'd0, 1'b1);
    drive(32'h8000_0000, 32'd1, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    drive(32'd0, 32'd1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int ra, rb;
      ra = int'($urandom_range(98, 0)) - 49;
      rb = int'($urandom_range(98, 0)) - 49;
      drive(ra, rb, 1'($urandom_range(1, 0)));
    end
    for (int i = 0; i < 10; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(1, 0)));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
